// File: rtl/fp_add_sub_iter_if.sv
// Handshake/data bundle for the iterative FP adder/subtractor.
// The producer/consumer side uses master; the adder uses slave.
interface fp_add_sub_iter_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         overflow;
  logic         invalid;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, overflow, invalid
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, overflow, invalid
  );
endinterface

// File: rtl/fp_add_sub_iter.sv
// Multi-cycle IEEE-754-style adder/subtractor with RNE rounding, Inf/NaN handling
// and one-bit-per-cycle left normalisation (data-dependent latency).
module fp_add_sub_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic              clk,
  input  logic              rst,
  fp_add_sub_iter_if.slave  bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 4;   // {hidden, frac, G, R, S}

  localparam logic [W-1:0]     QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [EXP_W:0]   EXP_ONE  = {{EXP_W{1'b0}}, 1'b1};
  localparam logic [EXP_W:0]   EXP_INF  = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W-1:0] DIFF_MAX = EXP_W'(MAN_W + 3);

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t state_r, next_s;

  logic [W-1:0]   a_r, b_r, result_r;
  logic           in_ready_r, out_valid_r, overflow_r, invalid_r;
  logic           sign_r, eff_sub_r;
  logic [EXP_W:0] exp_r;
  logic [MW:0]    man_r;          // extra top bit holds the add carry
  logic [MW-1:0]  mb_r;

  logic           transfer_s;
  logic           sa_s, sb_s;
  logic [EXP_W-1:0] ea_s, eb_s;
  logic [MAN_W-1:0] fa_s, fb_s;
  logic           a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
  logic           special_s, sp_inv_s;
  logic [W-1:0]   sp_res_s;

  logic           a_ge_s, sbig_s;
  logic [EXP_W-1:0] ebig_s, diff_s;
  logic [MW-1:0]  mbig_s, msml_full_s, msml_s;

  logic           inc_s, rovf_s;
  logic [MAN_W+1:0] rman_s;
  logic [MAN_W-1:0] rfrac_s;
  logic [EXP_W:0] rexp_s;
  logic [W-1:0]   rres_s;

  assign transfer_s = bus.in_valid & in_ready_r;

  assign sa_s = a_r[W-1];
  assign sb_s = b_r[W-1];
  assign ea_s = a_r[W-2:MAN_W];
  assign eb_s = b_r[W-2:MAN_W];
  assign fa_s = a_r[MAN_W-1:0];
  assign fb_s = b_r[MAN_W-1:0];

  // Operand classification and special-case result selection
  always_comb begin
    a_zero_s  = (ea_s == {EXP_W{1'b0}});
    b_zero_s  = (eb_s == {EXP_W{1'b0}});
    a_inf_s   = (ea_s == {EXP_W{1'b1}}) && (fa_s == {MAN_W{1'b0}});
    b_inf_s   = (eb_s == {EXP_W{1'b1}}) && (fb_s == {MAN_W{1'b0}});
    a_nan_s   = (ea_s == {EXP_W{1'b1}}) && (fa_s != {MAN_W{1'b0}});
    b_nan_s   = (eb_s == {EXP_W{1'b1}}) && (fb_s != {MAN_W{1'b0}});
    special_s = 1'b1;
    sp_inv_s  = 1'b0;
    sp_res_s  = {W{1'b0}};
    if (a_nan_s || b_nan_s || (a_inf_s && b_inf_s && (sa_s != sb_s))) begin
      sp_res_s = QNAN;
      sp_inv_s = 1'b1;
    end else if (a_inf_s) begin
      sp_res_s = a_r;
    end else if (b_inf_s) begin
      sp_res_s = b_r;
    end else if (a_zero_s && b_zero_s) begin
      sp_res_s = {sa_s & sb_s, {(W-1){1'b0}}};
    end else if (a_zero_s) begin
      sp_res_s = b_r;
    end else if (b_zero_s) begin
      sp_res_s = a_r;
    end else begin
      special_s = 1'b0;
    end
  end

  // Magnitude ordering and sticky-preserving alignment shift
  always_comb begin
    a_ge_s      = {ea_s, fa_s} >= {eb_s, fb_s};
    sbig_s      = a_ge_s ? sa_s : sb_s;
    ebig_s      = a_ge_s ? ea_s : eb_s;
    mbig_s      = a_ge_s ? {1'b1, fa_s, 3'b000} : {1'b1, fb_s, 3'b000};
    msml_full_s = a_ge_s ? {1'b1, fb_s, 3'b000} : {1'b1, fa_s, 3'b000};
    diff_s      = a_ge_s ? (ea_s - eb_s) : (eb_s - ea_s);
    if (diff_s > DIFF_MAX) begin
      msml_s = {{(MW-1){1'b0}}, 1'b1};
    end else begin
      msml_s    = msml_full_s >> diff_s;
      msml_s[0] = msml_s[0] | (|(msml_full_s & ~({MW{1'b1}} << diff_s)));
    end
  end

  // Round-to-nearest-even and exponent overflow to Inf
  always_comb begin
    inc_s  = man_r[2] & (man_r[1] | man_r[0] | man_r[3]);
    rman_s = {1'b0, man_r[MW-1:3]} + {{(MAN_W+1){1'b0}}, inc_s};
    if (rman_s[MAN_W+1]) begin
      rfrac_s = rman_s[MAN_W:1];
      rexp_s  = exp_r + EXP_ONE;
    end else begin
      rfrac_s = rman_s[MAN_W-1:0];
      rexp_s  = exp_r;
    end
    if (rexp_s >= EXP_INF) begin
      rres_s = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      rovf_s = 1'b1;
    end else begin
      rres_s = {sign_r, rexp_s[EXP_W-1:0], rfrac_s};
      rovf_s = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= next_s;
  end

  // FSM next-state logic
  always_comb begin
    next_s = state_r;
    case (state_r)
      S_IDLE:   if (transfer_s) next_s = S_UNPACK; else next_s = S_IDLE;
      S_UNPACK: if (special_s)  next_s = S_DONE;   else next_s = S_ALIGN;
      S_ALIGN:  next_s = S_ADD;
      S_ADD:    next_s = S_NORM;
      S_NORM: begin
        if (man_r[MW])                      next_s = S_ROUND;
        else if (man_r == {(MW+1){1'b0}})   next_s = S_DONE;
        else if (man_r[MW-1])               next_s = S_ROUND;
        else if (exp_r > EXP_ONE)           next_s = S_NORM;
        else                                next_s = S_DONE;
      end
      S_ROUND:  next_s = S_DONE;
      S_DONE:   if (out_valid_r && bus.out_ready) next_s = S_IDLE; else next_s = S_DONE;
      default:  next_s = S_IDLE;
    endcase
  end

  // Datapath, result and handshake registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= {W{1'b0}}; b_r <= {W{1'b0}}; result_r <= {W{1'b0}};
      in_ready_r <= 1'b1; out_valid_r <= 1'b0; overflow_r <= 1'b0; invalid_r <= 1'b0;
      sign_r <= 1'b0; eff_sub_r <= 1'b0; exp_r <= {(EXP_W+1){1'b0}};
      man_r <= {(MW+1){1'b0}}; mb_r <= {MW{1'b0}};
    end else begin
      in_ready_r  <= (next_s == S_IDLE);
      out_valid_r <= (state_r == S_DONE) && !(out_valid_r && bus.out_ready);
      case (state_r)
        S_IDLE: begin
          if (transfer_s) begin
            a_r        <= bus.a;
            b_r        <= {bus.b[W-1] ^ bus.sub, bus.b[W-2:0]};
            overflow_r <= 1'b0;
            invalid_r  <= 1'b0;
          end
        end
        S_UNPACK: begin
          if (special_s) begin
            result_r  <= sp_res_s;
            invalid_r <= sp_inv_s;
          end
        end
        S_ALIGN: begin
          sign_r    <= sbig_s;
          exp_r     <= {1'b0, ebig_s};
          man_r     <= {1'b0, mbig_s};
          mb_r      <= msml_s;
          eff_sub_r <= (sa_s != sb_s);
        end
        S_ADD: begin
          if (eff_sub_r) man_r <= man_r - {1'b0, mb_r};
          else           man_r <= man_r + {1'b0, mb_r};
        end
        S_NORM: begin
          if (man_r[MW]) begin
            man_r <= {1'b0, man_r[MW:2], man_r[1] | man_r[0]};
            exp_r <= exp_r + EXP_ONE;
          end else if (man_r == {(MW+1){1'b0}}) begin
            result_r <= {W{1'b0}};
          end else if (man_r[MW-1]) begin
            man_r <= man_r;
          end else if (exp_r > EXP_ONE) begin
            man_r <= man_r << 1;
            exp_r <= exp_r - EXP_ONE;
          end else begin
            result_r <= {sign_r, {(W-1){1'b0}}};
          end
        end
        S_ROUND: begin
          result_r   <= rres_s;
          overflow_r <= rovf_s;
        end
        S_DONE:  result_r <= result_r;
        default: result_r <= result_r;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.overflow  = overflow_r;
  assign bus.invalid   = invalid_r;
endmodule
